// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB definitions: transfer encodings, arbiter state encoding and
// default sizing used by the masters, the bridge and the arbiter.
package ahb_arbiter_pkg;

  localparam int unsigned DEF_NUM_MASTERS = 3;
  localparam int unsigned DEF_QUANTUM     = 16;
  localparam int unsigned IDX_W           = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_OWNED  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Arbitration context: tenure state, granted master and round-robin pointer
  typedef struct packed {
    arb_state_e       state;
    logic [IDX_W-1:0] owner;
    logic [IDX_W-1:0] ptr;
  } arb_ctx_t;

  // Grant may only move where a new transfer starts or the bus is idle
  function automatic logic is_boundary(input logic ready, input logic [1:0] trans);
    return ready && ((trans == HTRANS_IDLE) || (trans == HTRANS_NONSEQ));
  endfunction

  function automatic logic is_beat(input logic ready, input logic [1:0] trans);
    return ready && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));
  endfunction

endpackage

// File: rtl/ahb_arbiter_rr_picker.sv
// Combinational round-robin select: first requester searching upward from
// (ptr + 1), wrapping around to ptr itself last.
module ahb_arbiter_rr_picker
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   valid
);

  logic             hi_valid;
  logic             lo_valid;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scan downward so the lowest index in each half is the one left standing
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(ptr)) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = IDX_W'(i);
        end
      end
    end
    valid  = hi_valid | lo_valid;
    winner = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin grant with burst hold, locked tenures,
// a beat quantum and parking on master 0.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int unsigned QUANTUM     = DEF_QUANTUM
) (
  input  logic                   Hclk,
  input  logic                   Hresetn,
  input  logic [NUM_MASTERS-1:0] Hbusreq,
  input  logic [NUM_MASTERS-1:0] Hlock,
  input  logic [1:0]             Htrans,
  input  logic                   Hreadyin,
  output logic [NUM_MASTERS-1:0] Hgrant,
  output logic [1:0]             Hmaster,
  output logic [1:0]             Hmaster_d,
  output logic                   Hmastlock
);

  localparam int unsigned CNT_W = $clog2(QUANTUM + 1);

  arb_ctx_t               cur_q;
  arb_ctx_t               dec_nxt;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [IDX_W-1:0]       hmaster_q;
  logic [IDX_W-1:0]       hmaster_d_q;
  logic                   hmastlock_q;
  logic [CNT_W-1:0]       beat_cnt_q;

  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   boundary_c;
  logic                   beat_c;
  logic                   lock_hold_c;
  logic                   own_req_c;
  logic [NUM_MASTERS-1:0] others_c;
  logic                   quantum_hit_c;
  logic                   force_c;
  logic                   keep_c;

  ahb_arbiter_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) rr_picker (
    .req    (Hbusreq),
    .ptr    (cur_q.ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign boundary_c    = is_boundary(Hreadyin, Htrans);
  assign beat_c        = is_beat(Hreadyin, Htrans);
  assign lock_hold_c   = (cur_q.state == ST_LOCKED) && Hlock[cur_q.owner];
  assign others_c      = Hbusreq & ~grant_q;
  assign own_req_c     = (|(Hbusreq & grant_q)) && (cur_q.state != ST_PARK);
  assign quantum_hit_c = (beat_cnt_q >= CNT_W'(QUANTUM));
  assign force_c       = quantum_hit_c && (|others_c);
  assign keep_c        = own_req_c && (others_c == '0) && !force_c;

  // Arbitration decision; only acted on at a boundary outside a held lock
  always_comb begin
    dec_nxt = cur_q;
    if (boundary_c && !lock_hold_c) begin
      if (!pick_valid) begin
        dec_nxt.state = ST_PARK;
        dec_nxt.owner = '0;
      end else if (keep_c) begin
        dec_nxt.state = Hlock[cur_q.owner] ? ST_LOCKED : ST_OWNED;
      end else begin
        dec_nxt.owner = pick_idx;
        dec_nxt.ptr   = pick_idx;
        dec_nxt.state = Hlock[pick_idx] ? ST_LOCKED : ST_OWNED;
      end
    end
    grant_nxt                = '0;
    grant_nxt[dec_nxt.owner] = 1'b1;
  end

  // Everything freezes while the bridge stalls
  always_ff @(posedge Hclk) begin
    if (!Hresetn) begin
      cur_q       <= '{state: ST_PARK, owner: '0, ptr: IDX_W'(NUM_MASTERS - 1)};
      grant_q     <= NUM_MASTERS'(1);
      hmaster_q   <= '0;
      hmaster_d_q <= '0;
      hmastlock_q <= 1'b0;
      beat_cnt_q  <= '0;
    end else if (Hreadyin) begin
      cur_q       <= dec_nxt;
      grant_q     <= grant_nxt;
      hmaster_q   <= cur_q.owner;
      hmaster_d_q <= hmaster_q;
      hmastlock_q <= (cur_q.state == ST_LOCKED);
      if (grant_nxt != grant_q) begin
        beat_cnt_q <= '0;
      end else if (beat_c && !quantum_hit_c) begin
        beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      end
    end
  end

  assign Hgrant    = grant_q;
  assign Hmaster   = hmaster_q;
  assign Hmaster_d = hmaster_d_q;
  assign Hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter: directed steps push expected outputs,
// a negedge monitor pops and compares them.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] NS   = 2'b10;
  localparam logic [1:0] SEQ  = 2'b11;

  logic       Hclk = 1'b0;
  logic       Hresetn;
  logic [2:0] Hbusreq;
  logic [2:0] Hlock;
  logic [1:0] Htrans;
  logic       Hreadyin;
  logic [2:0] Hgrant;
  logic [1:0] Hmaster;
  logic [1:0] Hmaster_d;
  logic       Hmastlock;

  typedef struct {
    int         cyc;
    logic [2:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ahb_arbiter dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hbusreq   (Hbusreq),
    .Hlock     (Hlock),
    .Htrans    (Htrans),
    .Hreadyin  (Hreadyin),
    .Hgrant    (Hgrant),
    .Hmaster   (Hmaster),
    .Hmaster_d (Hmaster_d),
    .Hmastlock (Hmastlock)
  );

  always #5 Hclk = ~Hclk;

  always @(posedge Hclk) cyc <= cyc + 1;

  function automatic void cmp(input string name, input int c,
                              input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, c, act, want);
    end
  endfunction

  // Monitor: compare every expectation whose cycle has arrived
  always @(negedge Hclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      if (mon_e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale expectation: due cycle %0d, now %0d", mon_e.cyc, cyc);
      end else begin
        cmp("Hgrant",    cyc, Hgrant,               mon_e.g);
        cmp("Hmaster",   cyc, {1'b0, Hmaster},      {1'b0, mon_e.m});
        cmp("Hmaster_d", cyc, {1'b0, Hmaster_d},    {1'b0, mon_e.md});
        cmp("Hmastlock", cyc, {2'b00, Hmastlock},   {2'b00, mon_e.ml});
      end
    end
  end

  // Drive one cycle of inputs; expected values are the outputs after the edge
  task automatic step(input logic [2:0] breq, input logic [2:0] lck,
                      input logic [1:0] tr, input logic rdy,
                      input logic [2:0] g, input logic [1:0] m,
                      input logic [1:0] md, input logic ml);
    exp_t ex;
    Hbusreq  = breq;
    Hlock    = lck;
    Htrans   = tr;
    Hreadyin = rdy;
    ex.cyc = cyc + 1;
    ex.g   = g;
    ex.m   = m;
    ex.md  = md;
    ex.ml  = ml;
    exp_q.push_back(ex);
    @(posedge Hclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Hresetn  = 1'b0;
    Hbusreq  = 3'b111;
    Hlock    = 3'b000;
    Htrans   = NS;
    Hreadyin = 1'b1;
    @(posedge Hclk);
    #1;

    // Reset with all masters requesting
    step(3'b111, 3'b000, NS, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    step(3'b111, 3'b000, NS, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    Hresetn = 1'b1;

    // Fairness: master 0 first, then rotation, Hmaster one cycle behind
    step(3'b111, 3'b000, NS, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    step(3'b111, 3'b000, NS, 1'b1, 3'b010, 2'd0, 2'd0, 1'b0);
    step(3'b111, 3'b000, NS, 1'b1, 3'b100, 2'd1, 2'd0, 1'b0);
    step(3'b111, 3'b000, NS, 1'b1, 3'b001, 2'd2, 2'd1, 1'b0);
    step(3'b111, 3'b000, NS, 1'b1, 3'b010, 2'd0, 2'd2, 1'b0);

    // Burst hold: master 1 bursts, master 2 waits for the next NONSEQ
    step(3'b010, 3'b000, IDLE, 1'b1, 3'b010, 2'd1, 2'd0, 1'b0);
    step(3'b010, 3'b000, NS,   1'b1, 3'b010, 2'd1, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      step(3'b110, 3'b000, SEQ, 1'b1, 3'b010, 2'd1, 2'd1, 1'b0);
    step(3'b110, 3'b000, NS,   1'b1, 3'b100, 2'd1, 2'd1, 1'b0);
    step(3'b100, 3'b000, IDLE, 1'b1, 3'b100, 2'd2, 2'd1, 1'b0);

    // Stall in the middle of a handover 2 -> 0
    step(3'b001, 3'b000, NS, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0);
    for (int i = 0; i < 5; i++)
      step(3'b001, 3'b000, NS, 1'b0, 3'b001, 2'd2, 2'd2, 1'b0);
    step(3'b001, 3'b000, IDLE, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0);
    step(3'b001, 3'b000, IDLE, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);

    // Quantum: long stream from master 0, handover at the following boundary
    step(3'b001, 3'b000, NS, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 19; i++)
      step(3'b101, 3'b000, SEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    step(3'b101, 3'b000, NS,   1'b1, 3'b100, 2'd0, 2'd0, 1'b0);
    step(3'b100, 3'b000, IDLE, 1'b1, 3'b100, 2'd2, 2'd0, 1'b0);

    // Same stream locked: no handover until Hlock drops
    step(3'b001, 3'b001, IDLE, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0);
    step(3'b001, 3'b001, NS,   1'b1, 3'b001, 2'd0, 2'd2, 1'b1);
    for (int i = 0; i < 19; i++)
      step(3'b101, 3'b001, SEQ, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1);
    for (int i = 0; i < 2; i++)
      step(3'b101, 3'b001, NS, 1'b1, 3'b001, 2'd0, 2'd0, 1'b1);
    step(3'b101, 3'b000, NS,   1'b1, 3'b100, 2'd0, 2'd0, 1'b1);
    step(3'b100, 3'b000, IDLE, 1'b1, 3'b100, 2'd2, 2'd0, 1'b0);

    // Parking, pointer keeps last real owner (2)
    step(3'b000, 3'b000, IDLE, 1'b1, 3'b001, 2'd2, 2'd2, 1'b0);
    step(3'b000, 3'b000, IDLE, 1'b1, 3'b001, 2'd0, 2'd2, 1'b0);
    step(3'b100, 3'b000, IDLE, 1'b1, 3'b100, 2'd0, 2'd0, 1'b0);
    step(3'b100, 3'b000, IDLE, 1'b1, 3'b100, 2'd2, 2'd0, 1'b0);

    // Reset during a locked tenure, then master 0 favoured again
    step(3'b010, 3'b010, IDLE, 1'b1, 3'b010, 2'd2, 2'd2, 1'b0);
    step(3'b010, 3'b010, NS,   1'b1, 3'b010, 2'd1, 2'd2, 1'b1);
    Hresetn = 1'b0;
    step(3'b010, 3'b010, SEQ,  1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    Hresetn = 1'b1;
    step(3'b011, 3'b000, NS,   1'b1, 3'b001, 2'd0, 2'd0, 1'b0);
    step(3'b011, 3'b000, NS,   1'b1, 3'b010, 2'd0, 2'd0, 1'b0);

    repeat (2) @(negedge Hclk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
AHB_ARBITER -- requirements
Module: ahb_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3: number of AHB masters sharing Bridge_top; supported range 2..4.
REQ-002 SHALL have parameter QUANTUM, default 16: maximum completed beats per unlocked tenure before forced re-arbitration.
REQ-003 SHALL have port Hclk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port Hresetn, input, 1: synchronous active-low reset, sampled on the Hclk rising edge.
REQ-005 SHALL have port Hbusreq, input, NUM_MASTERS: per-master bus request.
REQ-006 SHALL have port Hlock, input, NUM_MASTERS: per-master locked-transfer request.
REQ-007 SHALL have port Htrans, input, 2: muxed transfer type of the current address-phase owner (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port Hreadyin, input, 1: transfer-complete from Bridge_top (Hreadyout looped back).
REQ-009 SHALL have port Hgrant, output, NUM_MASTERS: one-hot grant.
REQ-010 SHALL have port Hmaster, output, 2: address-phase owner index, drives the address/control mux.
REQ-011 SHALL have port Hmaster_d, output, 2: data-phase owner index, drives the Hwdata mux.
REQ-012 SHALL have port Hmastlock, output, 1: current address-phase transfer is locked.

Function
REQ-013 SHALL implement FSM states PARK (no requests, master 0 parked), OWNED (unlocked tenure), LOCKED (locked tenure).
REQ-014 SHALL hold all registers when Hreadyin=0, regardless of request changes.
REQ-015 SHALL treat a cycle as a boundary when Hreadyin=1 and Htrans is IDLE or NONSEQ; SEQ and BUSY are never boundaries.
REQ-016 SHALL re-arbitrate only at a boundary, and only when not LOCKED or when the locked owner has deasserted Hlock.
REQ-017 SHALL select the winner round-robin: the first requester searching upward from (last owner + 1) mod NUM_MASTERS.
REQ-018 SHALL keep the current owner at a boundary when it still requests, its beat count is below QUANTUM, and no other master requests.
REQ-019 SHALL force handover when the beat count reaches QUANTUM and any other master requests; the handover is deferred to the next boundary.
REQ-020 SHALL count beats as cycles with Hreadyin=1 and Htrans of NONSEQ or SEQ; the count resets to 0 on every grant change and saturates at QUANTUM.
REQ-021 SHALL register Hgrant one cycle after the arbitration decision.
REQ-022 SHALL update Hmaster from Hgrant on the next Hreadyin=1 cycle.
REQ-023 SHALL copy Hmaster into Hmaster_d on every Hreadyin=1 cycle, giving exactly one transfer of address/data pipeline offset.
REQ-024 SHALL enter LOCKED when the winner has Hlock=1, and SHALL set Hmastlock with Hmaster for that owner.
REQ-025 SHALL ignore QUANTUM while in LOCKED.
REQ-026 SHALL return to PARK with Hgrant=one-hot(0) when Hbusreq=0 at a boundary; the round-robin pointer SHALL keep the last real owner.
REQ-027 SHALL keep an owner that drops Hbusreq mid-burst (SEQ/BUSY) granted until the next boundary.
REQ-028 SHALL resolve simultaneous requests purely by the round-robin rule, with no fixed priority.

Reset
REQ-029 SHALL drive, while Hresetn=0 at a clock edge: state=PARK, Hgrant=one-hot(0), Hmaster=0, Hmaster_d=0, Hmastlock=0, round-robin pointer=NUM_MASTERS-1, beat count=0.
REQ-030 SHALL abandon any tenure, including a locked one, on reset mid-transfer; no state survives reset.
REQ-031 SHALL make the first arbitration after reset release favour master 0.

Structure
REQ-032 SHALL place the Htrans encodings, the FSM state encoding and the NUM_MASTERS/QUANTUM defaults in a shared package used by AHB_master, Bridge_top and this block.
REQ-033 SHALL contain one sub-module, rr_picker: combinational round-robin select, with inputs request vector and pointer and outputs winner index and valid.

Verification
REQ-034 SHALL cover reset: Hresetn=0 for 2 cycles with Hbusreq=111 -> Hgrant=001, Hmaster=0, Hmastlock=0; after release, master 0 wins first.
REQ-035 SHALL cover fairness: Hbusreq=111 held, single NONSEQ transfers, Hreadyin=1 -> grants rotate 001->010->100->001, and Hmaster follows one Hreadyin cycle later.
REQ-036 SHALL cover burst hold: master 1 runs NONSEQ+3 SEQ while master 2 requests -> Hgrant stays 010 until Htrans=IDLE/NONSEQ, then becomes 100.
REQ-037 SHALL cover stalls: Hreadyin=0 for 5 cycles during a handover -> Hgrant, Hmaster and Hmaster_d are frozen, then advance on the first Hreadyin=1.
REQ-038 SHALL cover quantum: with QUANTUM=16, master 0 streams SEQ while master 2 requests -> handover at the first boundary after beat 16; Hlock[0]=1 for the same stimulus -> no handover and Hmastlock=1.
REQ-039 SHALL cover parking: all Hbusreq drop at a boundary -> state PARK and Hgrant=001; master 2 then requests -> grant 100 within 2 cycles.
